mem_access_stage: RTL and testbench



---
 rtl/mem_stage_pkg.sv | 42 ++++
 rtl/mem_load_align.sv | 33 +++
 rtl/mem_access_stage.sv | 171 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the data-memory access stage: access-size codes,
// the access FSM state type and the store lane helpers.
package mem_stage_pkg;

   // MEM_Size encodings
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   // Access FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Store byte enables, big-endian: lane 0 is bits 31:24 (BE bit 3).
   function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] lane);
      logic [3:0] be;
      case (size)
         SZ_BYTE: be = 4'b1000 >> lane;
         SZ_HALF: be = lane[1] ? 4'b0011 : 4'b1100;
         SZ_WORD: be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   // Replicate right-justified store data across every lane it may occupy,
   // so the memory only needs the byte enables to pick the right bytes.
   function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
      logic [31:0] lanes;
      case (size)
         SZ_BYTE: lanes = {4{data[7:0]}};
         SZ_HALF: lanes = {2{data[15:0]}};
         default: lanes = data;
      endcase
      return lanes;
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load alignment: picks the addressed byte/half out of the read word
// (big-endian lane order) and sign- or zero-extends it to 32 bits.
module mem_load_align
   import mem_stage_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_lane,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Lane select and extension; purely combinational.
   always_comb begin
      w_byte = 8'h00;
      case (i_lane)
         2'd0:    w_byte = i_rdata[31:24];
         2'd1:    w_byte = i_rdata[23:16];
         2'd2:    w_byte = i_rdata[15:8];
         default: w_byte = i_rdata[7:0];
      endcase
      w_half = i_lane[1] ? i_rdata[15:0] : i_rdata[31:16];
      case (i_size)
         SZ_BYTE: o_data = i_unsigned ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
         SZ_HALF: o_data = i_unsigned ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline. Issues byte/half/word loads and
// stores to a word-wide memory, stalls the pipeline until the access
// completes, and flags malformed accesses and memory time-outs.
//
// Memory handshake: Mem_Req rises with Mem_Addr/WData/BE/We registered and
// stays high, with those fields stable, until the memory returns a one-cycle
// Mem_Ack (Mem_RData valid in that cycle) or TIMEOUT cycles pass; Mem_Req
// then drops for at least one cycle. Mem_Ack is only honoured while waiting.
module mem_access_stage
   import mem_stage_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int TIMEOUT = 15
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              MEM_MemRead,
   input  logic              MEM_MemWrite,
   input  logic [1:0]        MEM_Size,
   input  logic              MEM_Unsigned,
   input  logic [31:0]       MEM_Address,
   input  logic [31:0]       MEM_WriteData,
   output logic [31:0]       MEM_ReadData,
   output logic              Stall,
   output logic              AccessErr,
   output logic              Mem_Req,
   output logic              Mem_We,
   output logic [ADDR_W-1:0] Mem_Addr,
   output logic [31:0]       Mem_WData,
   output logic [3:0]        Mem_BE,
   input  logic [31:0]       Mem_RData,
   input  logic              Mem_Ack
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_e             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_mem_req;
   logic               r_mem_we;
   logic [ADDR_W-1:0]  r_mem_addr;
   logic [31:0]        r_mem_wdata;
   logic [3:0]         r_mem_be;
   logic [31:0]        r_rdata;
   logic               r_tmo;
   logic [1:0]         r_lane;
   logic [1:0]         r_size;
   logic               r_uns;

   logic               w_access;
   logic               w_bad_size;
   logic               w_misalign;
   logic               w_err;
   logic               w_valid;
   logic [CNT_W-1:0]   w_cnt_inc;
   logic               w_tmo_hit;
   logic [31:0]        w_ld_data;
   logic               w_unused;

   // Address bits above the memory window do not take part in the access.
   assign w_unused = ^MEM_Address[31:ADDR_W+2];

   // Classify the access presented by EX/MEM this cycle.
   always_comb begin
      w_access   = MEM_MemRead | MEM_MemWrite;
      w_bad_size = (MEM_Size == SZ_ILL);
      w_misalign = ((MEM_Size == SZ_HALF) && MEM_Address[0]) ||
                   ((MEM_Size == SZ_WORD) && (MEM_Address[1:0] != 2'b00));
      w_err      = w_access & ((MEM_MemRead & MEM_MemWrite) | w_bad_size | w_misalign);
      w_valid    = w_access & ~w_err;
      w_cnt_inc  = r_cnt + CNT_W'(1);
      w_tmo_hit  = (w_cnt_inc == CNT_W'(TIMEOUT));
   end

   // Lane/size/sign are captured at issue so the result does not depend on
   // the pipeline holding EX/MEM perfectly still during the wait.
   mem_load_align u_load_align (
      .i_rdata    (Mem_RData),
      .i_lane     (r_lane),
      .i_size     (r_size),
      .i_unsigned (r_uns),
      .o_data     (w_ld_data)
   );

   // Access FSM with time-out counter and registered memory-side outputs.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_be    <= '0;
         r_rdata     <= '0;
         r_tmo       <= 1'b0;
         r_lane      <= '0;
         r_size      <= '0;
         r_uns       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_cnt <= '0;
               r_tmo <= 1'b0;
               if (w_valid) begin
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= MEM_MemWrite;
                  r_mem_addr  <= MEM_Address[ADDR_W+1:2];
                  r_mem_wdata <= store_lanes(MEM_Size, MEM_WriteData);
                  r_mem_be    <= MEM_MemWrite ? be_gen(MEM_Size, MEM_Address[1:0]) : 4'b1111;
                  r_lane      <= MEM_Address[1:0];
                  r_size      <= MEM_Size;
                  r_uns       <= MEM_Unsigned;
                  r_state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // An ack in the time-out cycle still completes normally.
               if (Mem_Ack) begin
                  r_rdata   <= r_mem_we ? 32'h0 : w_ld_data;
                  r_mem_req <= 1'b0;
                  r_tmo     <= 1'b0;
                  r_state   <= ST_DONE;
               end else if (w_tmo_hit) begin
                  r_rdata   <= 32'h0;
                  r_mem_req <= 1'b0;
                  r_tmo     <= 1'b1;
                  r_state   <= ST_DONE;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state   <= ST_IDLE;
               r_mem_req <= 1'b0;
            end
         endcase
      end
   end

   // Pipeline-side outputs; all forced low while reset is held.
   always_comb begin
      Stall        = 1'b0;
      AccessErr    = 1'b0;
      MEM_ReadData = 32'h0;
      if (Rst_n) begin
         case (r_state)
            ST_IDLE: begin
               Stall     = w_valid;
               AccessErr = w_err;
            end
            ST_WAIT: Stall = 1'b1;
            ST_DONE: begin
               AccessErr    = r_tmo;
               MEM_ReadData = r_rdata;
            end
            default: Stall = 1'b0;
         endcase
      end
   end

   assign Mem_Req   = r_mem_req;
   assign Mem_We    = r_mem_we;
   assign Mem_Addr  = r_mem_addr;
   assign Mem_WData = r_mem_wdata;
   assign Mem_BE    = r_mem_be;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: a word memory responder with programmable ack
// delay, a byte-array reference model, and queue-based scoreboards for the
// memory request and the pipeline-side response.
module tb_mem_access_stage;
  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 15;
  localparam int NWORDS  = 1 << ADDR_W;
  localparam int NBYTES  = NWORDS * 4;
  localparam logic [1:0] B = 2'd0, H = 2'd1, W = 2'd2, ILL = 2'd3;

  logic              Clk, Rst_n;
  logic              MEM_MemRead, MEM_MemWrite, MEM_Unsigned;
  logic [1:0]        MEM_Size;
  logic [31:0]       MEM_Address, MEM_WriteData, MEM_ReadData;
  logic              Stall, AccessErr, Mem_Req, Mem_We, Mem_Ack;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [31:0]       Mem_WData, Mem_RData;
  logic [3:0]        Mem_BE;

  mem_access_stage #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .MEM_Size(MEM_Size), .MEM_Unsigned(MEM_Unsigned),
    .MEM_Address(MEM_Address), .MEM_WriteData(MEM_WriteData),
    .MEM_ReadData(MEM_ReadData), .Stall(Stall), .AccessErr(AccessErr),
    .Mem_Req(Mem_Req), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr),
    .Mem_WData(Mem_WData), .Mem_BE(Mem_BE),
    .Mem_RData(Mem_RData), .Mem_Ack(Mem_Ack)
  );

  // ---------------- clock ----------------
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [40:0] exp_q[$];   // {err, read_data, stall_cycles}
  logic [46:0] req_q[$];   // {we, word_addr, be, wdata}
  logic [31:0] phys  [NWORDS];
  logic [7:0]  ref_b [NBYTES];
  int ack_delay = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference load: assemble n bytes big-endian from the byte model, extend.
  function automatic logic [31:0] ref_load(input logic [11:0] a, input int n, input logic uns);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_b[int'(a) + i]);
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic set_word(input int idx, input logic [31:0] val);
    phys[idx] = val;
    for (int k = 0; k < 4; k++) ref_b[4*idx + k] = val[31-8*k -: 8];
  endtask

  // ---------------- driver ----------------
  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input int delay,
                       input int gap);
    logic [11:0] a;
    int n, stall;
    bit err, tmo, done;
    logic [31:0] rexp, wexp;
    logic [3:0]  bexp;
    a = addr[11:0];
    n = (sz == B) ? 1 : (sz == H) ? 2 : 4;
    err = (rd && wr) || (sz == ILL) || ((int'(a) % n) != 0);
    if (err) begin
      exp_q.push_back({1'b1, 32'h0, 8'd0});
    end else begin
      tmo   = (delay <= 0) || (delay > TIMEOUT);
      stall = tmo ? TIMEOUT + 1 : delay + 1;
      rexp  = (tmo || wr) ? 32'h0 : ref_load(a, n, uns);
      bexp  = 4'hF;
      if (wr) begin
        bexp = 4'h0;
        for (int i = 0; i < n; i++) bexp[3 - ((int'(a) + i) % 4)] = 1'b1;
      end
      wexp = (n == 1) ? {4{wdata[7:0]}} : (n == 2) ? {2{wdata[15:0]}} : wdata;
      req_q.push_back({wr, a[11:2], bexp, wexp});
      exp_q.push_back({tmo, rexp, 8'(stall)});
      if (wr && !tmo)
        for (int i = 0; i < n; i++) ref_b[int'(a) + i] = wdata[8*(n-1-i) +: 8];
    end
    ack_delay     = delay;
    MEM_MemRead   = rd;
    MEM_MemWrite  = wr;
    MEM_Size      = sz;
    MEM_Unsigned  = uns;
    MEM_Address   = addr;
    MEM_WriteData = wdata;
    done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge Clk);
      if (!Stall) done = 1'b1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL retire_budget: access at 0x%08h still stalled after 64 cycles", addr);
    end
    @(posedge Clk); #1;
    MEM_MemRead  = 1'b0;
    MEM_MemWrite = 1'b0;
    MEM_Address  = $urandom;
    repeat (gap) begin
      @(posedge Clk); #1;
    end
  endtask

  // ---------------- memory responder + request checker ----------------
  initial begin : responder
    int wait_cnt;
    logic [46:0] rq;
    Mem_Ack   = 1'b0;
    Mem_RData = 32'h0;
    wait_cnt  = 0;
    forever begin
      @(posedge Clk); #1;
      Mem_Ack   = 1'b0;
      Mem_RData = $urandom;
      if (!Rst_n) begin
        wait_cnt = 0;
      end else if (Mem_Req) begin
        wait_cnt++;
        if (wait_cnt == 1) begin
          check("req_expected", 32'(req_q.size() != 0), 32'd1);
          if (req_q.size() != 0) begin
            rq = req_q.pop_front();
            check("mem_we", 32'(Mem_We), 32'(rq[46]));
            check("mem_addr", 32'(Mem_Addr), 32'(rq[45:36]));
            check("mem_be", 32'(Mem_BE), 32'(rq[35:32]));
            if (rq[46]) check("mem_wdata", Mem_WData, rq[31:0]);
          end
        end
        if (ack_delay > 0 && wait_cnt == ack_delay) begin
          Mem_Ack = 1'b1;
          if (Mem_We)
            for (int j = 0; j < 4; j++)
              if (Mem_BE[j]) phys[Mem_Addr][8*j +: 8] = Mem_WData[8*j +: 8];
          Mem_RData = phys[Mem_Addr];
        end
      end else begin
        wait_cnt = 0;
        // Stray acks while no request is outstanding must be ignored.
        Mem_Ack = ($urandom_range(0, 7) == 0);
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin : monitor
    int stall_cnt;
    logic [40:0] e;
    stall_cnt = 0;
    forever begin
      @(negedge Clk);
      if (!Rst_n || !mon_en) begin
        stall_cnt = 0;
      end else if (MEM_MemRead || MEM_MemWrite) begin
        if (Stall) begin
          stall_cnt++;
          check("quiet_while_stalled", {AccessErr, MEM_ReadData}, 32'h0);
        end else begin
          check("resp_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("access_err", 32'(AccessErr), 32'(e[40]));
            check("read_data", MEM_ReadData, e[39:8]);
            check("stall_cycles", stall_cnt, 32'(e[7:0]));
            check("req_low_at_retire", 32'(Mem_Req), 32'd0);
          end
          stall_cnt = 0;
        end
      end else begin
        check("idle_quiet", {Mem_Req, Stall, AccessErr, |MEM_ReadData}, 32'h0);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    logic rd, wr, uns;
    logic [1:0] sz, lane;
    logic [31:0] addr;
    logic [19:0] hi;
    int r, dly;

    Rst_n = 1'b0;
    MEM_MemRead = 1'b1; MEM_MemWrite = 1'b0; MEM_Size = W; MEM_Unsigned = 1'b0;
    MEM_Address = 32'h0; MEM_WriteData = 32'h0;
    for (int i = 0; i < NWORDS; i++) set_word(i, $urandom);

    // Reset values, with an access presented to show outputs are held low.
    @(negedge Clk);
    check("rst_stall", 32'(Stall), 32'd0);
    check("rst_access_err", 32'(AccessErr), 32'd0);
    check("rst_read_data", MEM_ReadData, 32'h0);
    check("rst_mem_req", 32'(Mem_Req), 32'd0);
    check("rst_mem_we", 32'(Mem_We), 32'd0);
    check("rst_mem_addr", 32'(Mem_Addr), 32'd0);
    check("rst_mem_wdata", Mem_WData, 32'h0);
    check("rst_mem_be", 32'(Mem_BE), 32'd0);
    @(posedge Clk); #1;
    MEM_MemRead = 1'b0;
    @(posedge Clk); #1;
    Rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge Clk); #1;

    // Directed cases.
    set_word(0, 32'h1234_5680);
    issue(1'b1, 1'b0, B, 1'b0, 32'h0000_0003, 32'h0, 1, 0);            // lb  -> FFFFFF80
    issue(1'b1, 1'b0, H, 1'b1, 32'h0000_0002, 32'h0, 1, 1);            // lhu -> 00005680
    issue(1'b0, 1'b1, B, 1'b0, 32'h0000_0001, 32'h0000_00AB, 3, 0);    // sb
    issue(1'b1, 1'b0, W, 1'b0, 32'h0000_0000, 32'h0, 1, 0);            // lw back after sb
    issue(1'b1, 1'b0, W, 1'b0, 32'h0000_0006, 32'h0, 1, 0);            // misaligned lw
    issue(1'b1, 1'b0, W, 1'b0, 32'h0000_0008, 32'h0, 0, 1);            // time-out
    issue(1'b1, 1'b0, W, 1'b0, 32'h0000_000C, 32'h0, TIMEOUT, 0);      // ack on last cycle
    issue(1'b1, 1'b0, H, 1'b0, 32'h0000_0003, 32'h0, 1, 0);            // misaligned half
    issue(1'b1, 1'b0, ILL, 1'b0, 32'h0000_0000, 32'h0, 1, 0);          // illegal size
    issue(1'b1, 1'b1, B, 1'b0, 32'h0000_0000, 32'h0, 1, 0);            // read+write

    // Reset in the middle of a wait abandons the request.
    mon_en = 1'b0;
    ack_delay = 0;
    req_q.push_back({1'b0, 10'd4, 4'hF, 32'h0});
    MEM_MemRead = 1'b1; MEM_MemWrite = 1'b0; MEM_Size = W; MEM_Address = 32'h0000_0010;
    repeat (3) begin
      @(posedge Clk); #1;
    end
    @(negedge Clk);
    check("wait_req_high", 32'(Mem_Req), 32'd1);
    check("wait_stall_high", 32'(Stall), 32'd1);
    #2 Rst_n = 1'b0;
    #1;
    check("async_rst_req", 32'(Mem_Req), 32'd0);
    check("async_rst_stall", 32'(Stall), 32'd0);
    check("async_rst_err_data", {AccessErr, MEM_ReadData}, 32'h0);
    @(posedge Clk); #1;
    MEM_MemRead = 1'b0;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    @(posedge Clk); #1;
    mon_en = 1'b1;
    issue(1'b0, 1'b1, W, 1'b0, 32'h0000_0010, 32'hCAFE_F00D, 2, 0);    // sw after reset
    issue(1'b1, 1'b0, W, 1'b0, 32'h0000_0010, 32'h0, 1, 1);

    // Randomized traffic over a small window so loads see earlier stores.
    for (int t = 0; t < 250; t++) begin
      r  = $urandom_range(0, 99);
      rd = (r < 55);
      wr = !rd;
      if (r >= 95) begin rd = 1'b1; wr = 1'b1; end
      sz  = ($urandom_range(0, 19) == 0) ? ILL : 2'($urandom_range(0, 2));
      uns = 1'($urandom_range(0, 1));
      lane = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 8) begin
        if (sz == H) lane[0] = 1'b0;
        if (sz == W) lane = 2'b00;
      end
      hi   = ($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'h0;
      addr = {hi, 10'($urandom_range(0, 63)), lane};
      r = $urandom_range(0, 19);
      if (r == 0)      dly = 0;
      else if (r == 1) dly = TIMEOUT;
      else if (r == 2) dly = TIMEOUT + 1;
      else             dly = $urandom_range(1, 4);
      issue(rd, wr, sz, uns, addr, $urandom, dly, $urandom_range(0, 2));
    end

    repeat (5) @(posedge Clk);
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("req_q_drained", req_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
